// File: rtl/bitserial_logic_ctrl.sv
// Bit-serial bitwise-logic sequencer.
// Drives a shared external 1-bit logic cell one operand bit per cycle,
// LSB first, and assembles the cell's answers into a WIDTH-bit result.
// The controller never evaluates AND/OR/XOR/NOR itself; every result bit
// is taken from cell_rez.

module bitserial_logic_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             cell_a,
    output logic             cell_b,
    output logic [1:0]       cell_sel,
    input  logic             cell_rez,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Bit-index width, derived from WIDTH.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nx;
    logic             last_bit;

    // Incoming cell answer enters at the MSB; after WIDTH steps the first
    // (LSB) answer has travelled down to bit 0.
    assign shift_nx = {cell_rez, shift[WIDTH-1:1]};
    assign last_bit = (idx == CW'(WIDTH - 1));

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control outputs.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        cell_a   = 1'b0;
        cell_b   = 1'b0;
        unique case (state)
            S_IDLE: begin
                // start wins over abort here; abort only cancels RUN.
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                cell_a = a_reg[idx];
                cell_b = b_reg[idx];
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (last_bit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // The cell sees the operation latched at start, never the live op input.
    assign cell_sel = op_reg;

    // Operand capture, bit stepping and result assembly.
    // NOTE: every datapath register is reset, so result/zero have defined
    // values before the first operation and after a mid-operation reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 2'b00;
            shift  <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        idx    <= '0;
                        shift  <= '0;
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        shift <= shift_nx;
                        if (last_bit) begin
                            // Park the index at 0 rather than stepping past WIDTH-1.
                            idx    <= '0;
                            result <= shift_nx;
                            zero   <= (shift_nx == '0);
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
